// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into instruction memory and holds CPU_RST until it is complete.
// Optional BOOT_CHECKSUM_EN macro adds a trailing mod-256 checksum byte verified before release.
module imem_boot_loader #(
  parameter int RST_HOLD = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       RX_READY,
  output logic       IMEM_WE,
  output logic [7:0] IMEM_ADDR,
  output logic [7:0] IMEM_DATA,
  output logic       CPU_RST,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [8:0] LOADED_LEN
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(RST_HOLD + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
`ifdef BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  state_t         state;
  logic [7:0]     len_q;
  logic [8:0]     idx;
  logic [IW-1:0]  idle_cnt;
  logic [HW-1:0]  hold_cnt;
  logic           xfer;
  logic           rx_phase;
  logic           timed_out;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]     sum;
  logic [7:0]     ck_total;
  assign ck_total = sum + RX_DATA;
`endif

`ifdef BOOT_CHECKSUM_EN
  assign rx_phase = (state == S_LEN) || (state == S_LOAD) || (state == S_CHK);
`else
  assign rx_phase = (state == S_LEN) || (state == S_LOAD);
`endif

  assign RX_READY  = rx_phase;
  assign xfer      = RX_VALID && rx_phase;
  assign timed_out = !xfer && (idle_cnt == IW'(TIMEOUT - 1));
  assign CPU_RST   = (state != S_RUN);
  assign BUSY      = rx_phase || (state == S_HOLD);
  assign DONE      = (state == S_RUN);
  assign ERR       = (state == S_ERR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      IMEM_WE    <= 1'b0;
      IMEM_ADDR  <= 8'd0;
      IMEM_DATA  <= 8'd0;
      LOADED_LEN <= 9'd0;
      len_q      <= 8'd0;
      idx        <= 9'd0;
      idle_cnt   <= '0;
      hold_cnt   <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum        <= 8'd0;
`endif
    end else begin
      IMEM_WE <= 1'b0;
      if (rx_phase)
        idle_cnt <= xfer ? '0 : idle_cnt + 1'b1;

      unique case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (START) begin
            state      <= S_LEN;
            LOADED_LEN <= 9'd0;
            idx        <= 9'd0;
            idle_cnt   <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum        <= 8'd0;
`endif
          end
        end
        S_LEN: begin
          if (xfer) begin
            len_q <= RX_DATA;
            idx   <= 9'd0;
            // Image must be a whole number of 32-bit words: L+1 divisible by 4.
            state <= (RX_DATA[1:0] == 2'b11) ? S_LOAD : S_ERR;
          end else if (timed_out) begin
            state <= S_ERR;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            IMEM_WE    <= 1'b1;
            IMEM_ADDR  <= idx[7:0];
            IMEM_DATA  <= RX_DATA;
            LOADED_LEN <= LOADED_LEN + 9'd1;
            idx        <= idx + 9'd1;
`ifdef BOOT_CHECKSUM_EN
            sum        <= sum + RX_DATA;
`endif
            if (idx == {1'b0, len_q}) begin
              hold_cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
              state    <= S_CHK;
`else
              state    <= S_HOLD;
`endif
            end
          end else if (timed_out) begin
            state <= S_ERR;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            // The last write is already behind us, so the first HOLD cycle already counts.
            hold_cnt <= HW'(1);
            state    <= (ck_total == 8'd0) ? S_HOLD : S_ERR;
          end else if (timed_out) begin
            state <= S_ERR;
          end
        end
`endif
        S_HOLD: begin
          if (hold_cnt >= HW'(RST_HOLD))
            state <= S_RUN;
          else
            hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
